// File: rtl/lms_tap_sequencer_pkg.sv
// lms_ctrl_pkg: shared types and helpers for the LMS tap sequencer.
//   state_t    - sequencer FSM states
//   tap_idx_w  - index width for a count of N items, never less than 1 bit
package lms_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    FILTER,
    DRAIN,
    WAIT_ERR,
    UPDATE
  } state_t;

  function automatic int tap_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/lms_tap_sequencer_if.sv
// lms_sample_if: valid/ready sample stream feeding the sequencer.
//   in_valid  source -> sink   sample offered
//   in_ready  sink -> source   sample accepted when in_valid & in_ready
//   in_data   source -> sink   sample value, held stable while stalled
interface lms_sample_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/lms_tap_sequencer_tap_counter.sv
// tap_counter: loadable 0..N-1 index counter with a last flag.
//   clk, rstn  clock, asynchronous active-low reset
//   clr        force the index to 0 (has priority over inc)
//   inc        advance the index; saturates at N-1, never wraps
//   idx        current index
//   last       idx == N-1
module tap_counter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] idx,
  output logic         last
);
  localparam logic [W-1:0] LAST_IDX = W'(N - 1);

  logic [W-1:0] idx_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_reg <= '0;
    end else if (clr) begin
      idx_reg <= '0;
    end else if (inc && (idx_reg != LAST_IDX)) begin
      idx_reg <= idx_reg + W'(1);
    end
  end

  assign idx  = idx_reg;
  assign last = (idx_reg == LAST_IDX);
endmodule

// File: rtl/lms_tap_sequencer.sv
// lms_tap_sequencer: sequences one LMS adaptation iteration per input sample
// over a DEPTH-tap delay line: shift the sample in, run the FIR MAC pass,
// drain the MAC pipeline, wait for the error term, then run the weight
// update pass.
// Optional build macro: ADAPT_FREEZE_EN adds the adapt_freeze input; when it
// is high as the error term arrives the update pass is skipped.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   smp              sample stream (lms_sample_if slave)
//   shift_en/data    one-cycle delay-line shift strobe and sample
//   tap_idx          tap index for the MAC and update passes (0 elsewhere)
//   mac_clr/en/last  accumulator control for the FILTER pass
//   y_valid          filter output ready (last DRAIN cycle)
//   adapt_freeze     (ADAPT_FREEZE_EN only) skip this iteration's update
//   err_valid        error term available, only looked at in WAIT_ERR
//   wupd_en/last     weight update strobe and last-tap flag
//   done             one-cycle pulse on return to IDLE
//   busy             not in IDLE
module lms_tap_sequencer
  import lms_ctrl_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 32,
  parameter int MAC_LAT = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  lms_sample_if.slave                   smp,
  output logic                          shift_en,
  output logic [WIDTH-1:0]              shift_data,
  output logic [tap_idx_w(DEPTH)-1:0]   tap_idx,
  output logic                          mac_clr,
  output logic                          mac_en,
  output logic                          mac_last,
  output logic                          y_valid,
`ifdef ADAPT_FREEZE_EN
  input  logic                          adapt_freeze,
`endif
  input  logic                          err_valid,
  output logic                          wupd_en,
  output logic                          wupd_last,
  output logic                          done,
  output logic                          busy
);
  localparam int IDX_W = tap_idx_w(DEPTH);
  localparam int LAT_W = tap_idx_w(MAC_LAT);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MAC_LAT - 1);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   shift_data_reg;
  logic [LAT_W-1:0]   lat_reg;
  logic               done_reg;
  logic [IDX_W-1:0]   tap_cnt;
  logic               tap_last;
  logic               in_pass;
  logic               lat_last;

  // One counter serves both passes; it is held at 0 outside them and
  // cleared on the last tap so the following state sees index 0.
  assign in_pass = (state_reg == FILTER) || (state_reg == UPDATE);

  tap_counter #(.N(DEPTH), .W(IDX_W)) u_tap_counter (
    .clk  (clk),
    .rstn (rstn),
    .clr  (!in_pass || tap_last),
    .inc  (in_pass),
    .idx  (tap_cnt),
    .last (tap_last)
  );

  assign lat_last = (state_reg == DRAIN) && (lat_reg == LAT_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (smp.in_valid) state_next = SHIFT;
      SHIFT:    state_next = FILTER;
      FILTER:   if (tap_last) state_next = DRAIN;
      DRAIN:    if (lat_last) state_next = WAIT_ERR;
      WAIT_ERR: begin
        if (err_valid) begin
`ifdef ADAPT_FREEZE_EN
          state_next = adapt_freeze ? IDLE : UPDATE;
`else
          state_next = UPDATE;
`endif
        end
      end
      UPDATE:   if (tap_last) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      shift_data_reg <= '0;
      lat_reg        <= '0;
      done_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) && smp.in_valid) begin
        shift_data_reg <= smp.in_data;
      end
      lat_reg  <= ((state_reg == DRAIN) && !lat_last) ? lat_reg + LAT_W'(1) : '0;
      // Registered so done is a Moore pulse in the first IDLE cycle.
      done_reg <= (state_reg != IDLE) && (state_next == IDLE);
    end
  end

  assign smp.in_ready = (state_reg == IDLE);
  assign busy         = (state_reg != IDLE);
  assign shift_en     = (state_reg == SHIFT);
  assign shift_data   = shift_data_reg;
  assign tap_idx      = tap_cnt;
  assign mac_en       = (state_reg == FILTER);
  assign mac_clr      = (state_reg == FILTER) && (tap_cnt == '0);
  assign mac_last     = (state_reg == FILTER) && tap_last;
  assign y_valid      = lat_last;
  assign wupd_en      = (state_reg == UPDATE);
  assign wupd_last    = (state_reg == UPDATE) && tap_last;
  assign done         = done_reg;
endmodule
